conv_encoder_flush: RTL



---
 rtl/conv_enc_pkg.sv | 22 ++
 rtl/conv_enc_parity.sv | 19 +
 rtl/conv_encoder_flush.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the rate-1/2 terminated convolutional encoder.
// The puncture mask constants are only referenced when CONV_ENC_PUNCT_EN is defined.
package conv_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    typedef logic [1:0] symbol_t;

    localparam logic [2:0] G0_K3 = 3'b111;
    localparam logic [2:0] G1_K3 = 3'b101;

    // Bit 1 clear marks the G1 parity bit as an erasure for the channel.
    localparam logic [1:0] MASK_FULL  = 2'b11;
    localparam logic [1:0] MASK_PUNCT = 2'b01;

    localparam int TAIL_W = 3;

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity generator: forms {G1 parity, G0 parity} from the input bit and history.
module conv_enc_parity
    import conv_enc_pkg::*;
#(
    parameter int             K  = 3,
    parameter logic [K-1:0]   G0 = G0_K3,
    parameter logic [K-1:0]   G1 = G1_K3
) (
    input  logic         bit_i,
    input  logic [K-2:0] hist_i,
    output symbol_t      sym_o
);

    logic [K-1:0] window;

    assign window = {bit_i, hist_i};
    assign sym_o  = {^(window & G1), ^(window & G0)};

endmodule

// File: rtl/conv_encoder_flush.sv
// Rate-1/2 feedforward convolutional encoder that appends K-1 zero tail bits per frame.
// Optional macro CONV_ENC_PUNCT_EN adds the d_mask_o rate-2/3 puncture mask output.
module conv_encoder_flush
    import conv_enc_pkg::*;
#(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = G0_K3,
    parameter logic [K-1:0] G1 = G1_K3,
    parameter int           CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic          d_in,
    input  logic          last_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [1:0]    d_out,
    output logic          frame_done_o,
`ifdef CONV_ENC_PUNCT_EN
    output logic [CW-1:0] sym_ct_o,
    output logic [1:0]    d_mask_o
`else
    output logic [CW-1:0] sym_ct_o
`endif
);

    state_e              state_q, state_d;
    logic [K-2:0]        hist_q, hist_d;
    logic [TAIL_W-1:0]   tailCt_q, tailCt_d;
    logic [CW-1:0]       symCt_q, symCt_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    symbol_t             dout_q, dout_d;

    logic                accept;
    logic                encBit;
    logic [CW-1:0]       symCtInc;
    symbol_t             sym;

    assign ready_o  = (state_q != FLUSH);
    assign accept   = enable_i && ready_o;
    // During the tail the input is forced to zero so the trellis drains to state 0.
    assign encBit   = (state_q == FLUSH) ? 1'b0 : d_in;
    assign symCtInc = (symCt_q == '1) ? symCt_q : symCt_q + CW'(1);

    conv_enc_parity #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .bit_i  (encBit),
        .hist_i (hist_q),
        .sym_o  (sym)
    );

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        tailCt_d = tailCt_q;
        symCt_d  = symCt_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        dout_d   = dout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hist_d   = {encBit, hist_q[K-2:1]};
                    valid_d  = 1'b1;
                    dout_d   = sym;
                    symCt_d  = CW'(1);
                    tailCt_d = '0;
                    state_d  = last_i ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    hist_d   = {encBit, hist_q[K-2:1]};
                    valid_d  = 1'b1;
                    dout_d   = sym;
                    symCt_d  = symCtInc;
                    tailCt_d = '0;
                    if (last_i) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                hist_d   = {encBit, hist_q[K-2:1]};
                valid_d  = 1'b1;
                dout_d   = sym;
                symCt_d  = symCtInc;
                tailCt_d = tailCt_q + 1'b1;
                if (tailCt_q == TAIL_W'(K-2)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            tailCt_q <= '0;
            symCt_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            tailCt_q <= tailCt_d;
            symCt_q  <= symCt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
        end
    end

    assign valid_o      = valid_q;
    assign d_out        = dout_q;
    assign frame_done_o = done_q;
    assign sym_ct_o     = symCt_q;

`ifdef CONV_ENC_PUNCT_EN
    logic [1:0] mask_q, mask_d;
    logic       punctNext_q, punctNext_d;

    // punctNext_q is set when the next data symbol is even-indexed within the frame.
    always_comb begin
        mask_d      = mask_q;
        punctNext_d = punctNext_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mask_d      = MASK_FULL;
                    punctNext_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    mask_d      = punctNext_q ? MASK_PUNCT : MASK_FULL;
                    punctNext_d = ~punctNext_q;
                end
            end
            FLUSH: begin
                mask_d = MASK_FULL;
            end
            default: begin
                mask_d = MASK_FULL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= MASK_FULL;
            punctNext_q <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            punctNext_q <= punctNext_d;
        end
    end

    assign d_mask_o = mask_q;
`endif

endmodule
